// File: rtl/pipe_defs_pkg.sv
// Shared pipeline-buffer defaults for the 16-bit datapath.
// Provides field widths and the bubble encoding for all stage buffers.
package pipe_defs;

    localparam int DEF_PC_W   = 16;
    localparam int DEF_INST_W = 16;

    localparam logic [15:0] DEF_NOP_INST = 16'h0000;

    // Width of one stored entry: {pc, inst, bubble flag}
    function automatic int entry_w(input int pc_w, input int inst_w);
        return pc_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// DEPTH x W register array, one synchronous write port, one async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module pipe_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int W     = 33,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is intentionally not reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_df_pipe_fifo.sv
// IF->DF in-order queue of {pc, inst} with handshakes, flush, NOP insert.
// Ports: clk/rst, flush, in_* (fetch side), out_* (decode side), count.
module if_df_pipe_fifo
    import pipe_defs::*;
#(
    parameter int                PC_W     = DEF_PC_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            pc_buff_in,
    input  logic [INST_W-1:0]          inst_buff_in,
    input  logic                       nop_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            pc_buff_out,
    output logic [INST_W-1:0]          inst_buff_out,
    output logic                       out_bubble,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = entry_w(PC_W, INST_W);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    // No pass-through when full: a same-cycle pop does not free a slot.
    assign in_ready  = !rst && !flush && (count != CW'(DEPTH));
    assign out_valid = !flush && (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wdata = {pc_buff_in, nop_in ? NOP_INST : inst_buff_in, nop_in};

    pipe_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty (or flushing) presents a bubble at pc 0.
    always_comb begin
        pc_buff_out   = '0;
        inst_buff_out = NOP_INST;
        out_bubble    = 1'b1;
        if (out_valid) begin
            pc_buff_out   = rdata[EW-1 -: PC_W];
            inst_buff_out = rdata[INST_W:1];
            out_bubble    = rdata[0];
        end
    end

endmodule
